// File: rtl/lc3_pipeline_ctrl.sv
// lc3_pipeline_ctrl: LC3 pipeline stall/redirect controller (macro LC3_CTRL_BYPASS_EN enables ALU forwarding, else DEP stall)
//   clock, reset (async active-low), complete_instr, complete_data, IR (decode), IR_Exec (execute), NZP
//   -> enable_updatePC/fetch/decode/execute/writeback, br_taken, mem_state, bypass_alu_1/2
module lc3_pipeline_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2
);
    typedef enum logic [2:0] {RUN, MEM_IND, MEM_RD, MEM_WR, CTRL1, CTRL2, DEP} state_t;

    state_t     state, next;
    logic       started, dep1, dep2, dep_stall;
    logic [3:0] op_d, op_x;
    logic       unused;

    function automatic logic is_alu(input logic [3:0] op);
        return op inside {4'd1, 4'd5, 4'd9, 4'd14};
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return op inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd11};
    endfunction

    assign op_d   = IR[15:12];
    assign op_x   = IR_Exec[15:12];
    assign unused = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

    assign dep1 = is_alu(op_x) && (is_alu(op_d) || is_mem(op_d) || op_d == 4'd12) && IR_Exec[11:9] == IR[8:6];
    assign dep2 = is_alu(op_x) && (op_d == 4'd1 || op_d == 4'd5) && !IR[5] && IR_Exec[11:9] == IR[2:0];

`ifdef LC3_CTRL_BYPASS_EN
    assign bypass_alu_1 = started && state == RUN && dep1;
    assign bypass_alu_2 = started && state == RUN && dep2;
    assign dep_stall    = 1'b0;
`else
    assign bypass_alu_1 = 1'b0;
    assign bypass_alu_2 = 1'b0;
    assign dep_stall    = dep1 || dep2;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            started <= 1'b0;
        end else begin
            state   <= next;
            started <= 1'b1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            RUN:
                if (is_mem(op_x))
                    next = (op_x == 4'd10 || op_x == 4'd11) ? MEM_IND :
                           (op_x == 4'd2 || op_x == 4'd6) ? MEM_RD : MEM_WR;
                else if (dep_stall)
                    next = DEP;
                else if ((op_d == 4'd0 || op_d == 4'd12) && complete_instr)
                    next = CTRL1;
            MEM_IND: if (complete_data) next = (op_x == 4'd10) ? MEM_RD : MEM_WR;
            MEM_RD, MEM_WR: if (complete_data) next = RUN;
            CTRL1: next = CTRL2;
            default: next = RUN;
        endcase
    end

    // Only the RUN fetch-side enables look at complete_instr; everything else is a pure state decode.
    always_comb begin
        enable_updatePC  = started && ((state == RUN && complete_instr) || state == CTRL2);
        enable_fetch     = enable_updatePC;
        enable_decode    = started && state == RUN && complete_instr;
        enable_execute   = started && (state == RUN || state == CTRL1 || state == DEP);
        enable_writeback = started && (state == RUN || state == CTRL1 || state == CTRL2 || state == DEP);
        mem_state        = state == MEM_IND ? 2'd0 : state == MEM_RD ? 2'd1 : state == MEM_WR ? 2'd2 : 2'd3;
        br_taken         = state == CTRL2 && (op_x == 4'd12 || (op_x == 4'd0 && |(IR_Exec[11:9] & NZP)));
    end
endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// tb_lc3_pipeline_ctrl: directed self-checking bench for lc3_pipeline_ctrl
module tb_lc3_pipeline_ctrl;
    localparam logic [15:0] NEU = 16'hF025;
    localparam logic [4:0]  EN_ALL = 5'b11111, EN_NONE = 5'b00000, EN_EW = 5'b00011, EN_C2 = 5'b11001;

    logic        clock = 1'b0, reset, complete_instr, complete_data;
    logic [15:0] IR, IR_Exec;
    logic [2:0]  NZP;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, bypass_alu_1, bypass_alu_2;
    logic [1:0]  mem_state;
    int          passed = 0, total = 0;

    lc3_pipeline_ctrl dut (
        .clock(clock), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
        .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP),
        .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
        .mem_state(mem_state), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2)
    );

    always #5 clock = ~clock;

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [4:0] en, input logic br, input logic [1:0] ms, input logic [1:0] bp);
        logic [9:0] obs, exp;
        obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
               br_taken, mem_state, bypass_alu_1, bypass_alu_2};
        exp = {en, br, ms, bp};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic dep_case(input string tag, input logic [15:0] ir, input logic [15:0] irx, input logic [1:0] bp);
        nxt(); IR = ir; IR_Exec = irx; #1;
`ifdef LC3_CTRL_BYPASS_EN
        check(tag, EN_ALL, 0, 3, bp);
`else
        check(tag, EN_ALL, 0, 3, 2'b00);
        if (bp != 2'b00) begin
            nxt(); IR_Exec = NEU; #1;
            check({tag, "_dep"}, EN_EW, 0, 3, 2'b00);
        end
`endif
        nxt(); IR = NEU; IR_Exec = NEU; #1;
        check({tag, "_after"}, EN_ALL, 0, 3, 2'b00);
    endtask

    task automatic branch(input string tag, input logic [15:0] ir, input logic [2:0] nzp, input logic taken);
        nxt(); IR = ir; IR_Exec = NEU; NZP = nzp; #1;
        check({tag, "_run"}, EN_ALL, 0, 3, 2'b00);
        nxt(); IR = NEU; IR_Exec = ir; #1;
        check({tag, "_c1"}, EN_EW, 0, 3, 2'b00);
        nxt(); #1;
        check({tag, "_c2"}, EN_C2, taken, 3, 2'b00);
        nxt(); IR_Exec = NEU; #1;
        check({tag, "_back"}, EN_ALL, 0, 3, 2'b00);
    endtask

    initial begin
        reset = 1'b0; complete_instr = 1'b1; complete_data = 1'b0;
        IR = NEU; IR_Exec = NEU; NZP = 3'b000;
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            check("reset_hold", EN_NONE, 0, 3, 2'b00);
        end
        nxt(); reset = 1'b1; #1;
        check("release_first", EN_NONE, 0, 3, 2'b00);
        nxt(); #1;
        check("release_run", EN_ALL, 0, 3, 2'b00);
        nxt(); complete_instr = 1'b0; #1;
        check("run_no_instr", EN_EW, 0, 3, 2'b00);
        complete_instr = 1'b1;

        nxt(); IR_Exec = 16'h2200; #1;
        check("ld_issue", EN_ALL, 0, 3, 2'b00);
        for (int i = 0; i < 3; i++) begin
            nxt(); IR_Exec = NEU; complete_data = (i == 2); #1;
            check("ld_stall", EN_NONE, 0, 1, 2'b00);
        end
        nxt(); complete_data = 1'b0; #1;
        check("ld_done", EN_ALL, 0, 3, 2'b00);

        nxt(); IR_Exec = 16'hB000; #1;
        check("sti_issue", EN_ALL, 0, 3, 2'b00);
        nxt(); #1;
        check("sti_ind1", EN_NONE, 0, 0, 2'b00);
        nxt(); complete_data = 1'b1; #1;
        check("sti_ind2", EN_NONE, 0, 0, 2'b00);
        nxt(); complete_data = 1'b0; IR_Exec = NEU; #1;
        check("sti_wr1", EN_NONE, 0, 2, 2'b00);
        nxt(); complete_data = 1'b1; #1;
        check("sti_wr2", EN_NONE, 0, 2, 2'b00);
        nxt(); complete_data = 1'b0; #1;
        check("sti_done", EN_ALL, 0, 3, 2'b00);

        branch("brz_taken", 16'h0402, 3'b010, 1'b1);
        branch("brz_not", 16'h0402, 3'b001, 1'b0);
        branch("jmp", 16'hC1C0, 3'b000, 1'b1);

        dep_case("byp_add", 16'h1441, 16'h1261, 2'b11);
        dep_case("byp_ldr", 16'h6240, 16'h1261, 2'b10);
        dep_case("byp_src2", 16'h1081, 16'h1261, 2'b01);
        dep_case("byp_imm", 16'h10A1, 16'h1261, 2'b00);

        nxt(); IR_Exec = 16'h6000; #1;
        check("ldr_issue", EN_ALL, 0, 3, 2'b00);
        nxt(); IR_Exec = NEU; complete_data = 1'b0; #1;
        check("ldr_stall", EN_NONE, 0, 1, 2'b00);
        #2 reset = 1'b0; #1;
        check("mid_reset", EN_NONE, 0, 3, 2'b00);
        nxt(); #1;
        check("mid_reset_hold", EN_NONE, 0, 3, 2'b00);
        nxt(); reset = 1'b1; #1;
        check("mid_release_first", EN_NONE, 0, 3, 2'b00);
        nxt(); #1;
        check("mid_release_run", EN_ALL, 0, 3, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
